// File: rtl/sdma_pkg.sv
// sdma_pkg: shared bus constants and the capture-state type for the sdma_core slice.
package sdma_pkg;

   localparam int unsigned ADDR_W          = 18;
   localparam int unsigned BUS_DW          = 16;
   localparam int unsigned BUF_DEPTH       = 1024;
   localparam logic [15:0] READ_STATE_ADDR = 16'h4000;
   localparam logic [15:0] GAIN_ADDR       = 16'h4001;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      CAPTURE = 2'd2,
      SWAP    = 2'd3
   } cap_state_e;

endpackage

// File: rtl/sdma_fsmc.sv
// sdma_fsmc: synchronises the multiplexed MCU bus, latches address and write data,
// and drives the read data onto AD while the synchronised read strobe is low.
module sdma_fsmc
   import sdma_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   inout  wire  [ADDR_W-1:0] AD,
   input  logic              NADV,
   input  logic              NWE,
   input  logic              NOE,
   input  logic [BUS_DW-1:0] rd_data_i,
   output logic [ADDR_W-1:0] addr_o,
   output logic [BUS_DW-1:0] wr_data_o,
   output logic              wr_stb_c
);

   logic [2:0]        nadv_q;
   logic [2:0]        nwe_q;
   logic [1:0]        noe_q;
   logic [ADDR_W-1:0] addr_q;
   logic [BUS_DW-1:0] wr_data_q;
   logic              nadv_rise_c;

   assign nadv_rise_c = nadv_q[1] & ~nadv_q[2];
   assign wr_stb_c    = nwe_q[1] & ~nwe_q[2];

   // Write data is tracked while the strobe is low so its value at the rising edge is kept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         nadv_q    <= 3'b111;
         nwe_q     <= 3'b111;
         noe_q     <= 2'b11;
         addr_q    <= '0;
         wr_data_q <= '0;
      end else begin
         nadv_q <= {nadv_q[1:0], NADV};
         nwe_q  <= {nwe_q[1:0], NWE};
         noe_q  <= {noe_q[0], NOE};
         if (nadv_rise_c) addr_q <= AD;
         if (!nwe_q[1]) wr_data_q <= AD[BUS_DW-1:0];
      end
   end

   assign AD        = noe_q[1] ? {ADDR_W{1'bz}} : {2'b00, rd_data_i};
   assign addr_o    = addr_q;
   assign wr_data_o = wr_data_q;

endmodule

// File: rtl/sdma_core.sv
// sdma_core: trigger-armed ADC capture into a ping-pong buffer, read out over an FSMC bus.
// Define SDMA_GAIN_REG_EN to make gain_ctrl MCU-writable at 0x4001.
module sdma_core
   import sdma_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 12,
   parameter int unsigned BUF_DEPTH  = sdma_pkg::BUF_DEPTH,
   parameter int unsigned ADC_DIV    = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   inout  wire  [ADDR_W-1:0]     AD,
   input  logic                  NADV,
   input  logic                  NWE,
   input  logic                  NOE,
   input  logic [DATA_WIDTH-1:0] adc_data,
   input  logic                  signal_in,
   output logic                  adc_clk,
   output logic                  ADC_OE,
   output logic [1:0]            gain_ctrl
);

   localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
   localparam int unsigned HALF  = ADC_DIV / 2;
   localparam int unsigned DIV_W = $clog2(ADC_DIV);

   logic [ADDR_W-1:0]     addr;
   logic [BUS_DW-1:0]     wr_data;
   logic                  wr_stb_c;
   logic [2:0]            sig_q;
   logic                  trig_rise_c;
   logic [DIV_W-1:0]      div_q, div_d;
   logic                  adc_clk_q, adc_clk_d, tick_q, tick_d;
   cap_state_e            state_q, state_d;
   logic [PTR_W-1:0]      ptr_q, ptr_d;
   logic                  wbuf_q, wbuf_d, rr_q, rr_d, hs_q, hs_d;
   logic [1:0]            gain_q, gain_d;
   logic                  buf_we_c;
   logic [BUS_DW-1:0]     rd_data_q, rd_data_d;
   logic [DATA_WIDTH-1:0] mem_q [2*BUF_DEPTH];

   sdma_fsmc u_fsmc (
      .clk       (clk),
      .rst_n     (rst_n),
      .AD        (AD),
      .NADV      (NADV),
      .NWE       (NWE),
      .NOE       (NOE),
      .rd_data_i (rd_data_q),
      .addr_o    (addr),
      .wr_data_o (wr_data),
      .wr_stb_c  (wr_stb_c)
   );

   assign trig_rise_c = sig_q[1] & ~sig_q[2];

   // adc_clk divider; tick marks the cycle in which adc_clk has just risen.
   always_comb begin
      div_d     = div_q + DIV_W'(1);
      adc_clk_d = adc_clk_q;
      tick_d    = 1'b0;
      if (div_q == DIV_W'(HALF - 1)) begin
         div_d     = '0;
         adc_clk_d = ~adc_clk_q;
         tick_d    = ~adc_clk_q;
      end
   end

   // MCU register writes resolve before the swap decision, which uses the new reg_read.
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      wbuf_d   = wbuf_q;
      rr_d     = rr_q;
      hs_d     = hs_q;
      gain_d   = gain_q;
      buf_we_c = 1'b0;
      if (wr_stb_c) begin
         if (addr == ADDR_W'(READ_STATE_ADDR)) begin
            rr_d = wr_data[0];
            if (!wr_data[0]) hs_d = 1'b0;
         end
`ifdef SDMA_GAIN_REG_EN
         if (addr == ADDR_W'(GAIN_ADDR)) gain_d = wr_data[1:0];
`endif
      end
      case (state_q)
         IDLE: begin
            if (trig_rise_c) state_d = ARMED;
         end
         ARMED, CAPTURE: begin
            if (tick_q) begin
               buf_we_c = 1'b1;
               if (ptr_q == PTR_W'(BUF_DEPTH - 1)) begin
                  state_d = SWAP;
               end else begin
                  ptr_d   = ptr_q + PTR_W'(1);
                  state_d = CAPTURE;
               end
            end
         end
         SWAP: begin
            if (!rr_d) begin
               wbuf_d  = ~wbuf_q;
               hs_d    = 1'b1;
               ptr_d   = '0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // The MCU only ever sees the buffer that is not being written.
   always_comb begin
      rd_data_d = '0;
      if (addr < ADDR_W'(BUF_DEPTH)) begin
         rd_data_d = BUS_DW'(mem_q[{~wbuf_q, addr[PTR_W-1:0]}]);
      end else if (addr == ADDR_W'(READ_STATE_ADDR)) begin
         rd_data_d = BUS_DW'({hs_q, rr_q});
`ifdef SDMA_GAIN_REG_EN
      end else if (addr == ADDR_W'(GAIN_ADDR)) begin
         rd_data_d = BUS_DW'(gain_q);
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sig_q     <= '0;
         div_q     <= '0;
         adc_clk_q <= 1'b0;
         tick_q    <= 1'b0;
         state_q   <= IDLE;
         ptr_q     <= '0;
         wbuf_q    <= 1'b0;
         rr_q      <= 1'b0;
         hs_q      <= 1'b0;
         gain_q    <= 2'b00;
         rd_data_q <= '0;
      end else begin
         sig_q     <= {sig_q[1:0], signal_in};
         div_q     <= div_d;
         adc_clk_q <= adc_clk_d;
         tick_q    <= tick_d;
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         wbuf_q    <= wbuf_d;
         rr_q      <= rr_d;
         hs_q      <= hs_d;
         gain_q    <= gain_d;
         rd_data_q <= rd_data_d;
      end
   end

   always_ff @(posedge clk) begin
      if (buf_we_c) mem_q[{wbuf_q, ptr_q}] <= adc_data;
   end

`ifdef SDMA_GAIN_REG_EN
   logic unused_wr;
   assign unused_wr = ^wr_data[BUS_DW-1:2];
`else
   logic unused_wr;
   assign unused_wr = ^wr_data[BUS_DW-1:1];
`endif

   assign adc_clk   = adc_clk_q;
   assign ADC_OE    = 1'b0;
   assign gain_ctrl = gain_q;

endmodule

// File: tb/tb_sdma_core.sv
// tb_sdma_core: randomized frames checked against a frame-level model through a bus-read scoreboard.
module tb_sdma_core;

   localparam int DW    = 12;
   localparam int DEPTH = 1024;
   localparam int DIV   = 4;
`ifdef SDMA_GAIN_REG_EN
   localparam bit GAIN_EN = 1'b1;
`else
   localparam bit GAIN_EN = 1'b0;
`endif

   logic          clk       = 1'b0;
   logic          rst_n     = 1'b0;
   logic          nadv      = 1'b1;
   logic          nwe       = 1'b1;
   logic          noe       = 1'b1;
   logic [DW-1:0] adc_data  = '0;
   logic          signal_in = 1'b0;
   logic [17:0]   ad_drv    = '0;
   logic          ad_en     = 1'b0;
   wire  [17:0]   ad;
   wire           adc_clk;
   wire           adc_oe;
   wire  [1:0]    gain_ctrl;

   assign ad = ad_en ? ad_drv : 18'bz;

   sdma_core #(.DATA_WIDTH(DW), .BUF_DEPTH(DEPTH), .ADC_DIV(DIV)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .AD        (ad),
      .NADV      (nadv),
      .NWE       (nwe),
      .NOE       (noe),
      .adc_data  (adc_data),
      .signal_in (signal_in),
      .adc_clk   (adc_clk),
      .ADC_OE    (adc_oe),
      .gain_ctrl (gain_ctrl)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   // Model: the read-side frame, the status bits and the frame being collected.
   int exp_rd [DEPTH];
   bit exp_valid;
   int exp_hs, exp_rr, exp_gain;
   bit m_idle, m_armed, m_done, pattern_mode;
   int m_arm_cyc;
   int m_frame[$];
   int rise_n = 0;
   bit adc_prev = 1'b0;

   int exp_q[$];
   int addr_q[$];

   task automatic check(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic timeout_fail(input string nm);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: timed out waiting", nm);
   endtask

   function automatic int model_read(input int a);
      if (a < DEPTH) return exp_rd[a];
      if (a == 'h4000) return exp_hs * 2 + exp_rr;
      if (a == 'h4001) return exp_gain;
      return 0;
   endfunction

   task automatic reset_model();
      m_idle    = 1'b1;
      m_armed   = 1'b0;
      m_done    = 1'b0;
      m_frame.delete();
      exp_hs    = 0;
      exp_rr    = 0;
      exp_gain  = 0;
      exp_valid = 1'b0;
   endtask

   task automatic bus_addr(input int a);
      @(posedge clk); #1;
      ad_drv = 18'(a);
      ad_en  = 1'b1;
      nadv   = 1'b0;
      repeat (2) @(posedge clk);
      #1 nadv = 1'b1;
      repeat (4) @(posedge clk);
      #1 ad_en = 1'b0;
   endtask

   task automatic bus_read(input int a, input int e);
      bus_addr(a);
      exp_q.push_back(e);
      addr_q.push_back(a);
      @(posedge clk);
      #1 noe = 1'b0;
      repeat (6) @(posedge clk);
      #1 noe = 1'b1;
      repeat (4) @(posedge clk);
   endtask

   task automatic rd_model(input int a);
      bus_read(a, model_read(a));
   endtask

   task automatic bus_write(input int a, input int d);
      bus_addr(a);
      @(posedge clk); #1;
      ad_drv = 18'(d & 'hFFFF);
      ad_en  = 1'b1;
      nwe    = 1'b0;
      repeat (3) @(posedge clk);
      #1 nwe = 1'b1;
      repeat (4) @(posedge clk);
      #1 ad_en = 1'b0;
      if (a == 'h4000) begin
         exp_rr = d & 1;
         if (exp_rr == 0) exp_hs = 0;
      end else if (a == 'h4001 && GAIN_EN) begin
         exp_gain = d & 3;
      end
   endtask

   task automatic trigger();
      @(posedge clk);
      #1 signal_in = 1'b1;
      if (m_idle) begin
         m_idle    = 1'b0;
         m_armed   = 1'b1;
         m_arm_cyc = cyc;
      end
      repeat (4) @(posedge clk);
      #1 signal_in = 1'b0;
   endtask

   task automatic wait_idle(input string nm);
      int k = 0;
      while (!m_idle && k < 10000) begin
         @(posedge clk);
         k++;
      end
      if (!m_idle) timeout_fail(nm);
   endtask

   task automatic wait_done(input string nm);
      int k = 0;
      while (!m_done && k < 10000) begin
         @(posedge clk);
         k++;
      end
      if (!m_done) timeout_fail(nm);
   endtask

   task automatic rand_reads(input int n);
      for (int i = 0; i < n; i++) rd_model(int'($urandom_range(0, DEPTH - 1)));
   endtask

   // ADC source and frame model: a sample is taken at the first adc_clk rise >= 3 clk after the trigger.
   initial begin
      int v;
      forever begin
         @(posedge clk);
         #1;
         if (adc_clk && !adc_prev) begin
            rise_n++;
            v = int'($urandom_range(0, 4095));
            if (m_armed && cyc >= m_arm_cyc + 3) begin
               if (pattern_mode) v = 2000 + (m_frame.size() >> 6);
               m_frame.push_back(v);
               if (m_frame.size() == DEPTH) begin
                  m_armed = 1'b0;
                  m_done  = 1'b1;
               end
            end
            adc_data = DW'(v);
         end
         adc_prev = adc_clk;
         if (m_done && exp_rr == 0) begin
            for (int i = 0; i < DEPTH; i++) exp_rd[i] = m_frame[i];
            exp_valid = 1'b1;
            exp_hs    = 1;
            m_done    = 1'b0;
            m_idle    = 1'b1;
            m_frame.delete();
         end
      end
   end

   // Bus monitor: every read strobe pops one expected value.
   initial begin
      int e, a;
      forever begin
         @(negedge noe);
         repeat (5) @(posedge clk);
         #1;
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rd_unexpected: got %0d, expected no read", int'(ad));
         end else begin
            e = exp_q.pop_front();
            a = addr_q.pop_front();
            check($sformatf("rd_%0h", a), int'(ad), e);
         end
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1);
   end

   initial begin
      int r0;
      reset_model();
      pattern_mode = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_gain", int'(gain_ctrl), 0);
      check("rst_adc_clk", int'(adc_clk), 0);
      check("rst_adc_oe", int'(adc_oe), 0);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1 check("run_adc_oe", int'(adc_oe), 0);

      @(posedge clk);
      r0 = rise_n;
      repeat (400) @(posedge clk);
      check("adc_clk_rate", rise_n - r0, 400 / DIV);

      bus_read('h4000, 0);
      bus_read('h4001, 0);
      bus_read('h2ABC, 0);
      bus_read('h34000, 0);

      bus_write('h4001, 3);
      check("gain_pin", int'(gain_ctrl), GAIN_EN ? 3 : 0);
      bus_read('h4001, GAIN_EN ? 3 : 0);
      bus_write('h4001, 1);
      check("gain_pin2", int'(gain_ctrl), exp_gain);
      bus_write('h4002, 'hFFFF);
      rd_model('h4000);

      // Single patterned frame, then full readout under reg_read
      pattern_mode = 1'b1;
      trigger();
      wait_idle("frame1");
      repeat (5) @(posedge clk);
      bus_read('h4000, 2);
      bus_write('h4000, 1);
      bus_read('h4000, 3);
      for (int i = 0; i < DEPTH; i++) rd_model(i);
      bus_read(0, 2000);
      bus_read(64, 2001);
      bus_read(1023, 2015);
      bus_write('h4000, 0);
      bus_read('h4000, 0);

      // Swap held by reg_read
      pattern_mode = 1'b0;
      bus_write('h4000, 1);
      trigger();
      wait_done("frame2_hold");
      repeat (20) @(posedge clk);
      bus_read('h4000, 1);
      bus_read(64, 2001);
      rand_reads(16);
      bus_write('h4000, 0);
      repeat (3) @(posedge clk);
      bus_read('h4000, 2);
      rd_model(0);
      rd_model(1023);
      rand_reads(24);

      // Retriggers mid-frame must be ignored
      trigger();
      repeat (800) @(posedge clk);
      trigger();
      repeat (1500) @(posedge clk);
      trigger();
      wait_idle("frame3");
      repeat (5) @(posedge clk);
      bus_read('h4000, 2);
      rd_model(0);
      rd_model(1023);
      rand_reads(32);

      // Reset mid-capture, then a fresh frame
      trigger();
      repeat (600) @(posedge clk);
      #1 rst_n = 1'b0;
      reset_model();
      repeat (3) @(posedge clk);
      #1 check("midrst_gain", int'(gain_ctrl), 0);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      bus_read('h4000, 0);
      rd_model('h4001);
      trigger();
      wait_idle("frame4");
      repeat (5) @(posedge clk);
      bus_read('h4000, 2);
      rd_model(1023);
      rand_reads(16);

      repeat (10) @(posedge clk);
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL rd_pending: got %0d unanswered reads, expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/sdma_core.md
# sdma_core

Trigger-armed ADC capture engine with a ping-pong sample buffer, read out by an MCU over a multiplexed FSMC-style asynchronous bus. It generates the ADC sample clock, stores 1024-sample frames, and exposes the completed frame plus a handshake/status register to the MCU. It sits between the external ADC and the MCU memory interface.

## Interface
- DATA_WIDTH, 12: ADC sample width.
- BUF_DEPTH, 1024: samples per frame and per buffer.
- ADC_DIV, 4: clk cycles per adc_clk period. Even, at least 2.
- clk  in  1  system clock; all logic in this domain.
- rst_n  in  1  asynchronous active-low reset.
- AD  inout  18  multiplexed address/data bus. Address phase uses [17:0]; data uses [15:0]; bits [17:16] read back as 0.
- NADV  in  1  address-valid, active low.
- NWE  in  1  write strobe, active low.
- NOE  in  1  read strobe, active low.
- adc_data  in  DATA_WIDTH  ADC parallel output.
- signal_in  in  1  capture trigger; rising edge is active.
- adc_clk  out  1  ADC sample clock.
- ADC_OE  out  1  ADC output enable, active low.
- gain_ctrl  out  2  analog front-end gain select.

## Operation
- **Bus synchronisation:** NADV, NWE, NOE and signal_in pass through 2-FF synchronisers.
- **Address latch:** the bus address is latched from AD on the synchronised NADV rising edge.
- **Write:** on the synchronised NWE rising edge, AD[15:0] is written to the latched address.
- **Read:** while synchronised NOE is low, the block drives AD = {2'b0, rd_data}. Otherwise AD is high-Z.
- **Memory map (read):**
  - 0x0000–0x03FF: read-side buffer sample, zero-extended.
  - 0x4000: {14'b0, has_switched, reg_read}.
  - 0x4001: {14'b0, gain_ctrl}.
  - All other addresses read 0.
- **Memory map (write):**
  - 0x4000: reg_read <= data[0]. Writing 0 also clears has_switched.
  - 0x4001: gain_ctrl <= data[1:0].
  - All other writes are ignored.
- **adc_clk:** free-running square wave with period ADC_DIV clk cycles.
- **Sample tick:** asserted for one clk at each adc_clk rising edge.
- **ADC_OE:** driven 0 whenever rst_n is high.
- **Capture FSM states:**
  - IDLE → ARMED on a signal_in rising edge.
  - ARMED → CAPTURE on the next sample tick.
  - CAPTURE writes adc_data into write_buf[write_ptr] on each tick, then write_ptr increments.
  - CAPTURE → SWAP after the write at write_ptr = BUF_DEPTH-1.
  - SWAP: if reg_read = 0, toggle write_buf, set has_switched = 1, reset write_ptr to 0, and go to IDLE. If reg_read = 1, hold in SWAP and discard ticks until reg_read = 0.
- **Buffer roles:** the read side is always !write_buf, so MCU reads never observe a buffer being written.
- **Retrigger:** signal_in edges outside IDLE are ignored.

## Timing
- **Reset values:**
  - adc_clk = 0, gain_ctrl = 0, ADC_OE = 0, AD high-Z.
  - reg_read = 0, has_switched = 0, write_ptr = 0, write_buf = 0.
  - State = IDLE.
  - Buffer contents are undefined.
- **Bus latency:**
  - The address is usable 3 clk after the NADV rising edge.
  - rd_data is registered; it is valid no later than 4 clk after NOE falls.
  - The AD drive is released no later than 3 clk after NOE rises.
  - A write takes effect 3 clk after the NWE rising edge.
- **Capture latency:** the first sample is taken at the first tick at least 3 clk after the signal_in edge.
- **Frame length:** one frame takes BUF_DEPTH ticks. has_switched rises 1 clk after the last write.
- **Simultaneous events:** a buffer swap and an MCU status write in the same cycle resolve with the MCU write first; the swap then evaluates the new reg_read.
- **Reset mid-capture:** all state is discarded and the FSM returns to IDLE.

## Configuration
- SDMA_GAIN_REG_EN defined: gain_ctrl is MCU-writable at 0x4001.
- Without SDMA_GAIN_REG_EN: gain_ctrl is tied to 2'b00, writes to 0x4001 are ignored, and reads of 0x4001 return 0.

## Structure
- **Package sdma_pkg:**
  - Constants READ_STATE_ADDR = 16'h4000, GAIN_ADDR = 16'h4001, BUF_DEPTH.
  - Address width.
  - Capture-state enum {IDLE, ARMED, CAPTURE, SWAP}.
- **Sub-module sdma_fsmc:** bus synchronisers, address latch, write strobe/data output, tri-state read mux.
- The ping-pong buffer, adc_clk divider and capture FSM live in sdma_core.

## Test plan
- **Reset:** pulse rst_n low → gain_ctrl = 0, adc_clk = 0, has_switched = 0, AD = high-Z, read of 0x4000 returns 0.
- **Single frame:** reset, then a signal_in rising edge with adc_data = 2000 + (i>>6) per tick → has_switched = 1 after 1024 ticks; read of 0x4000 returns 2.
- **Frame readout:** after the single frame, write 0x4000 = 1, read 0x0000–0x03FF, write 0x4000 = 0 → addr 0 = 2000, addr 64 = 2001, addr 1023 = 2015; has_switched ends at 0.
- **Swap hold:** hold reg_read = 1 while a second frame completes → no swap and old data stays readable; after writing 0, the swap occurs and the new frame is readable.
- **Retrigger during capture:** signal_in toggles mid-frame → ignored; exactly 1024 samples are captured.
- **Gain register (SDMA_GAIN_REG_EN defined):** write 0x4001 = 3 → gain_ctrl = 2'b11, read of 0x4001 returns 3.
